// File: rtl/conv33_pkg.sv
// Shared definitions for the conv33 weight/bias fetch path: fetch-state
// encoding and the fixed 3x3 kernel-set layout.
package conv33_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

  localparam int         NUM_W         = 9;
  localparam logic [3:0] WORDS_PER_SET = 4'd10;
  localparam logic [3:0] BIAS_IDX      = 4'd9;

endpackage

// File: rtl/conv33_rd_pipe.sv
// Read-return tracker for a synchronous-read memory: an RD_LAT-deep valid pipe
// plus a count of reads still in flight.
module conv33_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic ret_valid,
  output logic empty
);

  localparam int CNT_W = $clog2(RD_LAT + 2);

  logic [RD_LAT-1:0] vld_q;
  logic [CNT_W-1:0]  cnt_q;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its sources, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      // Shift toward the MSB; the MSB marks the word arriving this cycle.
      vld_q <= RD_LAT'({vld_q, issue});
      case ({issue, ret_valid})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign ret_valid = vld_q[RD_LAT-1];
  assign empty     = (cnt_q == '0);

endmodule

// File: rtl/conv33_wbuf.sv
// Double-buffered 3x3 weight/bias fetch-and-hold unit. Optional last-set reuse
// is enabled by defining CONV33_WBUF_CACHE_EN.
module conv33_wbuf #(
  parameter int DATA_W = 8,
  parameter int BIAS_W = 32,
  parameter int MEM_W  = 32,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int NUM_W  = conv33_pkg::NUM_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_weight_en,
  input  logic                    read_weight_en,
  input  logic [ADDR_W-1:0]       base_addr,
  output logic                    weight_load_done,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [MEM_W-1:0]        mem_rdata,
  output logic [NUM_W*DATA_W-1:0] weights_out,
  output logic [BIAS_W-1:0]       bias_out,
  output logic                    weights_valid
);

  import conv33_pkg::*;

  localparam int WBANK_W = NUM_W * DATA_W;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] base_q, last_addr_q;
  logic [3:0]        issue_cnt_q, rx_cnt_q;
  logic [WBANK_W-1:0] sh_w_q, w_q;
  logic [BIAS_W-1:0] sh_b_q, b_q;
  logic              valid_q, done_q;
  logic              issue, ret_valid, pipe_empty, commit, last_word, cache_hit;

`ifdef CONV33_WBUF_CACHE_EN
  logic [ADDR_W-1:0] last_base_q;
  logic              tag_valid_q;
  assign cache_hit = tag_valid_q && valid_q && (base_addr == last_base_q);
`else
  assign cache_hit = 1'b0;
`endif

  assign issue     = (state_q == ST_FETCH) && load_weight_en && (issue_cnt_q < WORDS_PER_SET);
  assign last_word = ret_valid && (rx_cnt_q == BIAS_IDX);
  assign commit    = (state_q == ST_DONE) && read_weight_en;

  // The address bus parks on the last issued address between fetches.
  assign mem_rd_en = issue;
  assign mem_addr  = issue ? base_q + ADDR_W'(issue_cnt_q) : last_addr_q;

  conv33_rd_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .issue    (issue),
    .ret_valid(ret_valid),
    .empty    (pipe_empty)
  );

  always_comb begin
    // NOTE: default assigned first so every path drives state_d; no latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (load_weight_en) state_d = cache_hit ? ST_DONE : ST_FETCH;
      ST_FETCH: begin
        if (!load_weight_en) state_d = ST_DRAIN;
        else if (last_word)  state_d = ST_DONE;
      end
      ST_DRAIN: if (pipe_empty) state_d = ST_IDLE;
      ST_DONE:  if (commit || !load_weight_en) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: both banks are reset explicitly; a reset must leave the MAC
      // array seeing zeros, not stale weights.
      base_q      <= '0;
      last_addr_q <= '0;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
      sh_w_q      <= '0;
      sh_b_q      <= '0;
      w_q         <= '0;
      b_q         <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
`ifdef CONV33_WBUF_CACHE_EN
      last_base_q <= '0;
      tag_valid_q <= 1'b0;
`endif
    end else begin
      done_q <= (state_d == ST_DONE);
      if (issue) last_addr_q <= mem_addr;

      unique case (state_q)
        ST_IDLE: begin
          if (load_weight_en) begin
            base_q      <= base_addr;
            issue_cnt_q <= '0;
            rx_cnt_q    <= '0;
            // On reuse the shadow mirrors the committed set, so commit is a no-op.
            if (cache_hit) begin
              sh_w_q <= w_q;
              sh_b_q <= b_q;
            end
          end
        end
        ST_FETCH: begin
          if (issue) issue_cnt_q <= issue_cnt_q + 4'd1;
          if (ret_valid) begin
            rx_cnt_q <= rx_cnt_q + 4'd1;
            if (rx_cnt_q == BIAS_IDX) sh_b_q <= mem_rdata[BIAS_W-1:0];
            else sh_w_q[rx_cnt_q*DATA_W +: DATA_W] <= mem_rdata[DATA_W-1:0];
          end
`ifdef CONV33_WBUF_CACHE_EN
          if (!load_weight_en) tag_valid_q <= 1'b0;
`endif
        end
        ST_DRAIN: begin
          sh_w_q <= '0;
          sh_b_q <= '0;
        end
        ST_DONE: begin
          if (commit) begin
            w_q     <= sh_w_q;
            b_q     <= sh_b_q;
            valid_q <= 1'b1;
`ifdef CONV33_WBUF_CACHE_EN
            last_base_q <= base_q;
            tag_valid_q <= 1'b1;
`endif
          end else if (!load_weight_en) begin
            sh_w_q <= '0;
            sh_b_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign weight_load_done = done_q;
  assign weights_out      = w_q;
  assign bias_out         = b_q;
  assign weights_valid    = valid_q;

endmodule

// File: tb/tb_conv33_wbuf.sv
// Directed bench for conv33_wbuf: one instance at RD_LAT=1, one at RD_LAT=3,
// each fed by a behavioural synchronous-read memory.
module tb_conv33_wbuf;

  localparam logic [71:0] W_A = 72'h09_08_07_06_05_04_03_02_01;
  localparam logic [71:0] W_B = 72'h99_88_77_66_55_44_33_22_11;
  localparam logic [71:0] W_C = 72'hA8_A7_A6_A5_A4_A3_A2_A1_A0;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_load, a_read, a_done, a_rd_en, a_valid;
  logic [9:0]  a_base, a_addr;
  logic [31:0] a_rdata, a_b;
  logic [71:0] a_w;
  logic        b_load, b_read, b_done, b_rd_en, b_valid;
  logic [9:0]  b_base, b_addr;
  logic [31:0] b_b, b_p0, b_p1, b_p2;
  logic [71:0] b_w;
  logic [31:0] mem [0:1023];
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  conv33_wbuf #(.RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .load_weight_en(a_load), .read_weight_en(a_read),
    .base_addr(a_base), .weight_load_done(a_done), .mem_rd_en(a_rd_en),
    .mem_addr(a_addr), .mem_rdata(a_rdata), .weights_out(a_w),
    .bias_out(a_b), .weights_valid(a_valid)
  );

  conv33_wbuf #(.RD_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .load_weight_en(b_load), .read_weight_en(b_read),
    .base_addr(b_base), .weight_load_done(b_done), .mem_rd_en(b_rd_en),
    .mem_addr(b_addr), .mem_rdata(b_p2), .weights_out(b_w),
    .bias_out(b_b), .weights_valid(b_valid)
  );

  // Data is X unless a read was actually issued, so a mistimed capture shows up.
  always @(posedge clk) begin
    a_rdata <= a_rd_en ? mem[a_addr] : 'x;
    b_p0    <= b_rd_en ? mem[b_addr] : 'x;
    b_p1    <= b_p0;
    b_p2    <= b_p1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts in IDLE at cycle T; returns in cycle T+12 with DONE expected.
  task automatic a_fetch(input logic [9:0] base, input logic [71:0] hold_w);
    logic [9:0] ea;
    a_load = 1'b1;
    a_base = base;
    tick();
    for (int k = 0; k < 10; k++) begin
      ea = base + 10'(k);
      chk("fetch_rd_en", a_rd_en, 1);
      chk("fetch_addr", a_addr, ea);
      chk("fetch_hold_w", a_w, hold_w);
      a_base = 10'h2AA;
      tick();
    end
    ea = base + 10'd9;
    chk("post_rd_en", a_rd_en, 0);
    chk("post_addr_hold", a_addr, ea);
    chk("post_done", a_done, 0);
    tick();
    chk("done", a_done, 1);
    chk("done_hold_w", a_w, hold_w);
  endtask

  task automatic a_commit(input logic [71:0] ew, input logic [31:0] eb);
    a_read = 1'b1;
    tick();
    a_read = 1'b0;
    a_load = 1'b0;
    chk("commit_w", a_w, ew);
    chk("commit_b", a_b, eb);
    chk("commit_valid", a_valid, 1);
    chk("commit_done_low", a_done, 0);
    chk("commit_rd_en", a_rd_en, 0);
  endtask

  initial begin
    logic [9:0] ea;
    rst = 1'b1;
    {a_load, a_read, b_load, b_read} = '0;
    a_base = '0;
    b_base = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hEEEE_0000 | 32'(i);
    for (int k = 0; k < 9; k++) begin
      mem[10'h010 + 10'(k)] = 32'(k + 1);
      mem[10'h020 + 10'(k)] = 32'h11 * 32'(k + 1);
      ea = 10'h3FC + 10'(k);
      mem[ea] = 32'hFFFF_FF00 | 32'(8'hA0 + 8'(k));
    end
    mem[10'h019] = 32'h0000_0100;
    mem[10'h029] = 32'hDEAD_BEEF;
    mem[10'h005] = 32'h1234_5678;

    repeat (2) tick();
    chk("rst_done", a_done, 0);
    chk("rst_rd_en", a_rd_en, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_w", a_w, 0);
    chk("rst_b", a_b, 0);
    chk("rst_valid", a_valid, 0);
    rst = 1'b0;
    tick();

    // Basic load of set A, then commit with load still high.
    a_fetch(10'h010, 72'h0);
    a_commit(W_A, 32'h0000_0100);
    tick();
    chk("idle_rd_en", a_rd_en, 0);

    // Set B fetched while A stays committed.
    a_fetch(10'h020, W_A);
    repeat (2) begin
      tick();
      chk("dbuf_hold_w", a_w, W_A);
      chk("dbuf_hold_done", a_done, 1);
    end
    a_commit(W_B, 32'hDEAD_BEEF);

    // Abort after four issues.
    a_load = 1'b1;
    a_base = 10'h010;
    tick();
    for (int k = 0; k < 4; k++) begin
      ea = 10'h010 + 10'(k);
      chk("abort_issue", a_rd_en, 1);
      chk("abort_addr", a_addr, ea);
      tick();
    end
    a_load = 1'b0;
    #1;
    chk("abort_rd_en_same_cycle", a_rd_en, 0);
    chk("abort_addr_hold", a_addr, 10'h013);
    repeat (5) begin
      tick();
      chk("abort_no_done", a_done, 0);
      chk("abort_rd_en", a_rd_en, 0);
      chk("abort_keep_w", a_w, W_B);
      chk("abort_keep_valid", a_valid, 1);
    end
    a_fetch(10'h010, W_B);
    a_commit(W_A, 32'h0000_0100);

`ifdef CONV33_WBUF_CACHE_EN
    a_load = 1'b1;
    a_base = 10'h010;
    tick();
    chk("hit_rd_en", a_rd_en, 0);
    chk("hit_done", a_done, 1);
    a_base = 10'h2AA;
    a_commit(W_A, 32'h0000_0100);
    a_fetch(10'h020, W_A);
    a_commit(W_B, 32'hDEAD_BEEF);
`else
    a_fetch(10'h010, W_A);
    a_commit(W_A, 32'h0000_0100);
`endif

    // Asynchronous reset in the middle of a fetch.
    a_load = 1'b1;
    a_base = 10'h020;
    repeat (3) tick();
    chk("pre_rst_rd_en", a_rd_en, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rd_en", a_rd_en, 0);
    chk("arst_done", a_done, 0);
    chk("arst_w", a_w, 0);
    chk("arst_b", a_b, 0);
    chk("arst_valid", a_valid, 0);
    chk("arst_addr", a_addr, 0);
    a_load = 1'b0;
    rst = 1'b0;
    tick();
    a_read = 1'b1;
    tick();
    a_read = 1'b0;
    chk("post_rst_read_valid", a_valid, 0);
    chk("post_rst_read_w", a_w, 0);
    tick();
    chk("post_rst_read_done", a_done, 0);

    // RD_LAT=3 instance, base wrapping past the top of memory.
    b_load = 1'b1;
    b_base = 10'h3FC;
    tick();
    for (int k = 0; k < 10; k++) begin
      ea = 10'h3FC + 10'(k);
      chk("lat3_rd_en", b_rd_en, 1);
      chk("lat3_addr", b_addr, ea);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      chk("lat3_wait_rd_en", b_rd_en, 0);
      chk("lat3_wait_done", b_done, 0);
      tick();
    end
    chk("lat3_done", b_done, 1);
    b_read = 1'b1;
    tick();
    b_read = 1'b0;
    b_load = 1'b0;
    chk("lat3_w", b_w, W_C);
    chk("lat3_b", b_b, 32'h1234_5678);
    chk("lat3_valid", b_valid, 1);
    chk("lat3_done_low", b_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
